// File: rtl/y86_mem_pkg.sv
// Shared data-memory definitions: array geometry, FSM state and read-owner encodings.
package y86_mem_pkg;

   localparam int DEPTH  = 1024;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 64;
   localparam int IDX_W  = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_M = 1'b1
   } owner_e;

   function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
      return (addr < ADDR_W'(DEPTH));
   endfunction

endpackage

// File: rtl/mem_starve_ctr.sv
// Saturating count of consecutive arbitration cycles in which a pending fetch was denied.
module mem_starve_ctr #(
   parameter int MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic at_max_o
);

   localparam int CW = $clog2(MAX + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over increment; the count holds once it reaches MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {CW{1'b0}};
      end else if (inc_i && (cnt_q != CW'(MAX))) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_max_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data-memory access controller shared by fetch (read-only) and memory stage (read/write).
module mem_arbiter
   import y86_mem_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_err,
   input  logic              m_req,
   input  logic              m_we,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_gnt,
   output logic              m_rvalid,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [IDX_W-1:0]  mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int LW = $clog2(MEM_LAT + 1);

   state_e        state_q, state_d;
   owner_e        owner_q, owner_d;
   logic [LW-1:0] lat_cnt_q, lat_cnt_d;

   logic              idle_s;
   logic              f_win_s;
   logic              m_win_s;
   logic              at_max_s;
   logic [ADDR_W-1:0] req_addr_s;
   logic              legal_s;
   logic              acc_en_s;
   logic              acc_we_s;
   logic              rd_start_s;
   logic              rvalid_s;

   // Outputs are forced low while reset is held so a read caught mid-flight never surfaces.
   assign idle_s = rst_n && (state_q == IDLE);

   // Memory stage has priority unless fetch has been denied STARVE_MAX cycles in a row.
   always_comb begin
      f_win_s = 1'b0;
      m_win_s = 1'b0;
      if (idle_s) begin
         if (f_req && (!m_req || at_max_s)) begin
            f_win_s = 1'b1;
         end else if (m_req) begin
            m_win_s = 1'b1;
         end else begin
            f_win_s = 1'b0;
            m_win_s = 1'b0;
         end
      end else begin
         f_win_s = 1'b0;
         m_win_s = 1'b0;
      end
   end

   assign req_addr_s = f_win_s ? f_addr : m_addr;
   assign legal_s    = addr_in_range(req_addr_s);
   assign acc_en_s   = (f_win_s || m_win_s) && legal_s;
   assign acc_we_s   = m_win_s && m_we && legal_s;
   assign rd_start_s = acc_en_s && !acc_we_s;

   assign f_gnt     = f_win_s;
   assign m_gnt     = m_win_s;
   assign f_err     = f_win_s && !legal_s;
   assign m_err     = m_win_s && !legal_s;
   assign mem_en    = acc_en_s;
   assign mem_we    = acc_we_s;
   assign mem_addr  = acc_en_s ? req_addr_s[IDX_W-1:0] : {IDX_W{1'b0}};
   assign mem_wdata = acc_we_s ? m_wdata : {DATA_W{1'b0}};

   assign rvalid_s  = rst_n && (state_q == WAIT) && (lat_cnt_q == LW'(1));
   assign f_rvalid  = rvalid_s && (owner_q == OWN_F);
   assign m_rvalid  = rvalid_s && (owner_q == OWN_M);
   assign f_rdata   = f_rvalid ? mem_rdata : {DATA_W{1'b0}};
   assign m_rdata   = m_rvalid ? mem_rdata : {DATA_W{1'b0}};
   assign busy      = rst_n && (state_q == WAIT);

   mem_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_i    (idle_s && f_req && !f_win_s),
      .clr_i    (idle_s && (!f_req || f_win_s)),
      .at_max_o (at_max_s)
   );

   // Read sequencing: a legal read parks the FSM in WAIT until the array latency elapses.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      lat_cnt_d = lat_cnt_q;
      case (state_q)
         IDLE: begin
            if (rd_start_s) begin
               state_d   = WAIT;
               owner_d   = f_win_s ? OWN_F : OWN_M;
               lat_cnt_d = LW'(MEM_LAT);
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (lat_cnt_q <= LW'(1)) begin
               state_d   = IDLE;
               lat_cnt_d = {LW{1'b0}};
            end else begin
               state_d   = WAIT;
               lat_cnt_d = lat_cnt_q - LW'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            lat_cnt_d = {LW{1'b0}};
         end
      endcase
   end

   // FSM state, read owner and latency counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= OWN_F;
         lat_cnt_q <= {LW{1'b0}};
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         lat_cnt_q <= lat_cnt_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int DEPTH  = 1024;
   localparam int STARVE = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        f_req, m_req, m_we;
   logic [63:0] f_addr, m_addr, m_wdata;
   logic        f_gnt, f_rvalid, f_err, m_gnt, m_rvalid, m_err, mem_en, mem_we, busy;
   logic [63:0] f_rdata, m_rdata, mem_wdata, mem_rdata;
   logic [9:0]  mem_addr;

   logic        f_req3, m_req3, m_we3;
   logic [63:0] f_addr3, m_addr3, m_wdata3;
   logic        f_gnt3, f_rvalid3, f_err3, m_gnt3, m_rvalid3, m_err3, mem_en3, mem_we3, busy3;
   logic [63:0] f_rdata3, m_rdata3, mem_wdata3, mem_rdata3;
   logic [9:0]  mem_addr3;

   int checks = 0;
   int errors = 0;
   logic [63:0] ref_mem [0:DEPTH-1];

   mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
      .m_rdata(m_rdata), .m_err(m_err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req3), .f_addr(f_addr3), .f_gnt(f_gnt3), .f_rvalid(f_rvalid3), .f_rdata(f_rdata3), .f_err(f_err3),
      .m_req(m_req3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_gnt(m_gnt3), .m_rvalid(m_rvalid3),
      .m_rdata(m_rdata3), .m_err(m_err3), .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
   );

   // Array models: one-cycle array for dut, three-stage read pipeline for dut3.
   logic [63:0] arr1 [0:DEPTH-1];
   logic [63:0] rd1;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) arr1[mem_addr] <= mem_wdata;
         else        rd1 <= arr1[mem_addr];
      end
   end
   assign mem_rdata = rd1;

   logic [63:0] arr3 [0:DEPTH-1];
   logic [63:0] p0, p1, p2;
   always @(posedge clk) begin
      if (mem_en3) begin
         if (mem_we3) arr3[mem_addr3] <= mem_wdata3;
         else         p0 <= arr3[mem_addr3];
      end
      p1 <= p0;
      p2 <= p1;
   end
   assign mem_rdata3 = p2;

   // Requesters must hold request and payload until granted.
   a_f_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (f_req && !f_gnt) |=> (f_req && $stable(f_addr)))
      else $error("FAIL protocol_f_hold");
   a_m_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (m_req && !m_gnt) |=> (m_req && $stable(m_addr) && $stable(m_we) && $stable(m_wdata)))
      else $error("FAIL protocol_m_hold");

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rand_addr();
      logic [63:0] a;
      if ($urandom_range(0, 7) != 0) begin
         a = 64'($urandom_range(0, DEPTH - 1));
      end else begin
         a = {$urandom, $urandom} | (64'd1 << $urandom_range(10, 63));
      end
      return a;
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      f_req = 1'b0; f_addr = 64'd0; m_req = 1'b0; m_we = 1'b0; m_addr = 64'd0; m_wdata = 64'd0;
      f_req3 = 1'b0; f_addr3 = 64'd0; m_req3 = 1'b0; m_we3 = 1'b0; m_addr3 = 64'd0; m_wdata3 = 64'd0;
      repeat (3) step();
      @(negedge clk);
      checks++;
      if ({f_gnt, f_rvalid, f_err, m_gnt, m_rvalid, m_err, mem_en, mem_we, busy} !== 9'b0)
         begin errors++; $display("FAIL reset_flags: got %b expected 0", {f_gnt, f_rvalid, f_err, m_gnt, m_rvalid, m_err, mem_en, mem_we, busy}); end
      checks++;
      if ((f_rdata | m_rdata | mem_wdata | {54'd0, mem_addr}) !== 64'd0)
         begin errors++; $display("FAIL reset_data: got nonzero data/addr outputs, expected 0"); end
      checks++;
      if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b expected 0", busy3); end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back;
      logic [63:0] d;
      for (int a = 0; a < DEPTH; a++) begin
         d = {$urandom, $urandom};
         ref_mem[a] = d;
         m_req = 1'b1; m_we = 1'b1; m_addr = 64'(a); m_wdata = d;
         @(negedge clk);
         checks++;
         if ({m_gnt, m_err, mem_en, mem_we, f_gnt, busy} !== 6'b101100)
            begin errors++; $display("FAIL b2b_flags[%0d]: got %b expected 101100", a, {m_gnt, m_err, mem_en, mem_we, f_gnt, busy}); end
         checks++;
         if (mem_addr !== 10'(a)) begin errors++; $display("FAIL b2b_addr: got %0d expected %0d", mem_addr, a); end
         checks++;
         if (mem_wdata !== d) begin errors++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", a, mem_wdata, d); end
         step();
      end
      m_req = 1'b0; m_we = 1'b0;
      step();
   endtask

   task automatic test_write_read;
      m_req = 1'b1; m_we = 1'b1; m_addr = 64'd5; m_wdata = 64'hDEAD;
      ref_mem[5] = 64'hDEAD;
      @(negedge clk);
      checks++;
      if ({m_gnt, mem_en, mem_we} !== 3'b111) begin errors++; $display("FAIL wr5_grant: got %b expected 111", {m_gnt, mem_en, mem_we}); end
      step();
      m_req = 1'b0; m_we = 1'b0; f_req = 1'b1; f_addr = 64'd5;
      @(negedge clk);
      checks++;
      if ({f_gnt, f_err, mem_en, mem_we, busy} !== 5'b10100) begin errors++; $display("FAIL rd5_grant: got %b expected 10100", {f_gnt, f_err, mem_en, mem_we, busy}); end
      step();
      f_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({f_rvalid, busy, f_gnt} !== 3'b110) begin errors++; $display("FAIL rd5_rvalid: got %b expected 110", {f_rvalid, busy, f_gnt}); end
      checks++;
      if (f_rdata !== 64'hDEAD) begin errors++; $display("FAIL rd5_data: got %h expected dead", f_rdata); end
      step();
   endtask

   task automatic test_errors;
      m_req = 1'b1; m_we = 1'b1; m_addr = 64'd1024; m_wdata = 64'h1234;
      @(negedge clk);
      checks++;
      if ({m_gnt, m_err, mem_en, mem_we} !== 4'b1100) begin errors++; $display("FAIL err_m_write: got %b expected 1100", {m_gnt, m_err, mem_en, mem_we}); end
      step();
      m_req = 1'b0; m_we = 1'b0; f_req = 1'b1; f_addr = 64'hFFFF_0000;
      @(negedge clk);
      checks++;
      if ({f_gnt, f_err, mem_en} !== 3'b110) begin errors++; $display("FAIL err_f_read: got %b expected 110", {f_gnt, f_err, mem_en}); end
      step();
      f_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({f_rvalid, f_err, busy} !== 3'b000) begin errors++; $display("FAIL err_no_rvalid: got %b expected 000", {f_rvalid, f_err, busy}); end
      step();
      m_req = 1'b1; m_addr = 64'd0;
      step();
      m_req = 1'b0;
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_rdata !== ref_mem[0]) begin errors++; $display("FAIL err_array_intact: got %b/%h expected 1/%h", m_rvalid, m_rdata, ref_mem[0]); end
      step();
   endtask

   task automatic test_starve;
      logic [63:0] fa, ma;
      int k;
      logic exp_f;
      logic drop_f;
      fa = 64'($urandom_range(0, DEPTH - 1));
      ma = 64'($urandom_range(0, DEPTH - 1));
      f_req = 1'b1; f_addr = fa; m_req = 1'b1; m_we = 1'b0; m_addr = ma;
      k = 0; drop_f = 1'b0;
      for (int c = 0; c < 80 && k < 11; c++) begin
         @(negedge clk);
         if (f_rvalid) begin
            checks++;
            if (f_rdata !== ref_mem[fa]) begin errors++; $display("FAIL starve_f_data: got %h expected %h", f_rdata, ref_mem[fa]); end
         end
         if (m_rvalid) begin
            checks++;
            if (m_rdata !== ref_mem[ma]) begin errors++; $display("FAIL starve_m_data: got %h expected %h", m_rdata, ref_mem[ma]); end
         end
         if (f_gnt || m_gnt) begin
            k++;
            exp_f = ((k % 5) == 0);
            checks++;
            if ({f_gnt, m_gnt} !== {exp_f, ~exp_f}) begin errors++; $display("FAIL starve_winner[%0d]: got f=%b m=%b expected f=%b", k, f_gnt, m_gnt, exp_f); end
            if (f_gnt && k >= 10) drop_f = 1'b1;
         end
         step();
         if (drop_f) f_req = 1'b0;
      end
      m_req = 1'b0;
      checks++;
      if (k != 11) begin errors++; $display("FAIL starve_budget: got %0d arbitrations expected 11", k); end
      @(negedge clk);
      checks++;
      if (m_rvalid !== 1'b1 || m_rdata !== ref_mem[ma]) begin errors++; $display("FAIL starve_last_read: got %b/%h expected 1/%h", m_rvalid, m_rdata, ref_mem[ma]); end
      step();
   endtask

   task automatic test_reset_mid_read;
      m_req = 1'b1; m_we = 1'b0; m_addr = 64'd3;
      @(negedge clk);
      checks++;
      if ({m_gnt, mem_en} !== 2'b11) begin errors++; $display("FAIL rstmid_grant: got %b expected 11", {m_gnt, mem_en}); end
      step();
      m_req = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({f_gnt, f_rvalid, f_err, m_gnt, m_rvalid, m_err, mem_en, mem_we, busy} !== 9'b0)
         begin errors++; $display("FAIL rstmid_flags: got %b expected 0", {f_gnt, f_rvalid, f_err, m_gnt, m_rvalid, m_err, mem_en, mem_we, busy}); end
      checks++;
      if (m_rdata !== 64'd0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 0", m_rdata); end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_rvalid, busy} !== 2'b00) begin errors++; $display("FAIL rstmid_after: got %b expected 00", {m_rvalid, busy}); end
      step();
   endtask

   task automatic test_lat3;
      logic [63:0] d;
      d = {$urandom, $urandom};
      m_req3 = 1'b1; m_we3 = 1'b1; m_addr3 = 64'd9; m_wdata3 = d;
      @(negedge clk);
      checks++;
      if ({m_gnt3, mem_en3, mem_we3} !== 3'b111) begin errors++; $display("FAIL lat3_write: got %b expected 111", {m_gnt3, mem_en3, mem_we3}); end
      step();
      m_req3 = 1'b0; m_we3 = 1'b0; f_req3 = 1'b1; f_addr3 = 64'd9;
      @(negedge clk);
      checks++;
      if ({f_gnt3, mem_en3, busy3} !== 3'b110) begin errors++; $display("FAIL lat3_grant: got %b expected 110", {f_gnt3, mem_en3, busy3}); end
      step();
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         checks++;
         if ({busy3, f_gnt3, f_rvalid3} !== {1'b1, 1'b0, (j == 3)}) begin errors++; $display("FAIL lat3_wait[%0d]: got %b expected %b", j, {busy3, f_gnt3, f_rvalid3}, {1'b1, 1'b0, (j == 3)}); end
         checks++;
         if (f_rdata3 !== ((j == 3) ? d : 64'd0)) begin errors++; $display("FAIL lat3_data[%0d]: got %h expected %h", j, f_rdata3, (j == 3) ? d : 64'd0); end
         step();
      end
      @(negedge clk);
      checks++;
      if ({f_gnt3, busy3} !== 2'b10) begin errors++; $display("FAIL lat3_next_grant: got %b expected 10", {f_gnt3, busy3}); end
      step();
      f_req3 = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_random;
      logic pf, pm, mwe, win_f, win_m, legal;
      logic [63:0] fa, ma, md, a, exp_rd, e_frd, e_mrd;
      logic [8:0] e_flags;
      logic [9:0] e_addr;
      logic [63:0] e_wdata;
      int busy_left, starve, cyc;
      logic own_f;
      pf = 1'b0; pm = 1'b0; busy_left = 0; starve = 0; own_f = 1'b0;
      fa = 64'd0; ma = 64'd0; md = 64'd0; mwe = 1'b0; exp_rd = 64'd0;
      cyc = 0;
      while ((cyc < 400 || pf || pm) && cyc < 600) begin
         if (cyc < 400 && !pf && ($urandom_range(0, 1) == 1)) begin pf = 1'b1; fa = rand_addr(); end
         if (cyc < 400 && !pm && ($urandom_range(0, 1) == 1)) begin
            pm = 1'b1; ma = rand_addr(); mwe = 1'($urandom_range(0, 1)); md = {$urandom, $urandom};
         end
         f_req = pf; f_addr = fa; m_req = pm; m_addr = ma; m_we = mwe; m_wdata = md;
         e_flags = 9'b0; e_frd = 64'd0; e_mrd = 64'd0; e_addr = 10'd0; e_wdata = 64'd0;
         win_f = 1'b0; win_m = 1'b0;
         // e_flags = {f_gnt, m_gnt, f_err, m_err, mem_en, mem_we, f_rvalid, m_rvalid, busy}
         if (busy_left > 0) begin
            e_flags[0] = 1'b1;
            if (busy_left == 1) begin
               if (own_f) begin e_flags[2] = 1'b1; e_frd = exp_rd; end
               else       begin e_flags[1] = 1'b1; e_mrd = exp_rd; end
            end
            busy_left--;
         end else begin
            win_f = pf && (!pm || starve == STARVE);
            win_m = pm && !win_f;
            if (pf && !win_f) starve = (starve < STARVE) ? starve + 1 : STARVE;
            else              starve = 0;
            if (win_f || win_m) begin
               a = win_f ? fa : ma;
               legal = (a < 64'(DEPTH));
               e_flags[8] = win_f; e_flags[7] = win_m;
               if (!legal) begin
                  e_flags[6] = win_f; e_flags[5] = win_m;
               end else if (win_m && mwe) begin
                  e_flags[4] = 1'b1; e_flags[3] = 1'b1; e_addr = a[9:0]; e_wdata = md;
                  ref_mem[a[9:0]] = md;
               end else begin
                  e_flags[4] = 1'b1; e_addr = a[9:0];
                  busy_left = 1; own_f = win_f; exp_rd = ref_mem[a[9:0]];
               end
            end
         end
         @(negedge clk);
         checks++;
         if ({f_gnt, m_gnt, f_err, m_err, mem_en, mem_we, f_rvalid, m_rvalid, busy} !== e_flags)
            begin errors++; $display("FAIL rand_flags[%0d]: got %b expected %b", cyc, {f_gnt, m_gnt, f_err, m_err, mem_en, mem_we, f_rvalid, m_rvalid, busy}, e_flags); end
         checks++;
         if (f_rdata !== e_frd || m_rdata !== e_mrd)
            begin errors++; $display("FAIL rand_rdata[%0d]: got f=%h m=%h expected f=%h m=%h", cyc, f_rdata, m_rdata, e_frd, e_mrd); end
         checks++;
         if (mem_addr !== e_addr || mem_wdata !== e_wdata)
            begin errors++; $display("FAIL rand_array[%0d]: got %0d/%h expected %0d/%h", cyc, mem_addr, mem_wdata, e_addr, e_wdata); end
         if (win_f) pf = 1'b0;
         if (win_m) pm = 1'b0;
         step();
         cyc++;
      end
      checks++;
      if (pf || pm) begin errors++; $display("FAIL rand_drain: got pending f=%b m=%b expected none", pf, pm); end
      f_req = 1'b0; m_req = 1'b0; m_we = 1'b0;
      step();
      step();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_write_read();
      test_errors();
      test_starve();
      test_reset_mid_read();
      test_lat3();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port access controller that shares the 1024-word, 64-bit data memory between the fetch port (read-only) and the memory stage (read/write). Arbitrates with memory-stage priority plus a fetch anti-starvation override, sequences each read through the array's fixed read latency, and flags out-of-range addresses before they reach the array. Sits between the fetch/memory-stage logic and the data memory array.

## Interface
- DEPTH, 1024, memory words; legal word index 0..DEPTH-1
- DATA_W, 64, data width
- MEM_LAT, 1, cycles from array sample to valid mem_rdata (>=1)
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch wins
- Clk  in  1  clock, all state on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- f_req  in  1  fetch read request; held until f_gnt
- f_addr  in  64  fetch word address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  64  fetch read data
- f_err  out  1  fetch address out of range (pulse)
- m_req  in  1  memory-stage request; held until m_gnt
- m_we  in  1  1 = write, 0 = read
- m_addr  in  64  memory-stage word address
- m_wdata  in  64  write data
- m_gnt  out  1  memory-stage request accepted
- m_rvalid  out  1  m_rdata valid
- m_rdata  out  64  memory-stage read data
- m_err  out  1  memory-stage address out of range (pulse)
- mem_en  out  1  array access strobe
- mem_we  out  1  array write enable
- mem_addr  out  10  array word index (log2 DEPTH)
- mem_wdata  out  64  array write data
- mem_rdata  in  64  array read data, valid MEM_LAT cycles after sample
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, WAIT. Registered: state, owner (F/M), lat_cnt, starve_cnt.
- IDLE arbitration (combinational): both requesting -> M wins unless starve_cnt == STARVE_MAX, then F wins. Single requester wins.
- Grant cycle: winner's gnt = 1. Address check: addr >= DEPTH (any of bits 63:10 set) -> err = 1 same cycle, mem_en = 0, stay IDLE, no rvalid.
- Legal write (M only): mem_en = mem_we = 1, mem_addr/mem_wdata driven from m_* same cycle; stay IDLE; no rvalid.
- Legal read: mem_en = 1, mem_we = 0; owner <- winner, lat_cnt <- MEM_LAT, go WAIT.
- WAIT: no grants, mem_en = 0; lat_cnt decrements; in cycle lat_cnt == 1 owner's rvalid = 1, rdata = mem_rdata (pass-through); next state IDLE.
- rdata outputs 0 whenever rvalid = 0.
- starve_cnt: +1 (saturating at STARVE_MAX) each IDLE cycle f_req = 1 and f_gnt = 0; cleared on f_gnt or f_req = 0. Not changed in WAIT.
- Err requests count as grants (request consumed, starvation rules apply).
- Requester dropping req or changing addr/wdata before gnt: protocol violation, assertion in bench.

## Timing
- Reset (Rst_n = 0 at edge): state = IDLE, lat_cnt = 0, starve_cnt = 0; all outputs 0 next cycle. Reset during WAIT discards the pending read; no rvalid emitted.
- Grant/err/write: zero-cycle, combinational from req in IDLE.
- Read granted in cycle N: rvalid in cycle N+MEM_LAT; earliest next grant N+MEM_LAT+1.
- Writes: one per cycle back-to-back. Reads: one per MEM_LAT+1 cycles.
- Write to address A in cycle N, read of A granted in N+1 returns new data.

## Structure
- Shared package y86_mem_pkg: state enum (IDLE, WAIT), owner enum (OWN_F, OWN_M), DEPTH, DATA_W, address index width constant; reused by the memory array and pipeline stages.
- One sub-module natural: mem_starve_ctr (saturating counter, inc/clr inputs, at_max output). Remainder in mem_arbiter.

## Test plan
- Reset mid-read: read granted, Rst_n = 0 next cycle -> no m_rvalid, busy = 0, all outputs 0.
- M write addr 5 data 0xDEAD, then F read addr 5 -> f_gnt, f_rvalid at grant+1 with f_rdata = 0xDEAD.
- Both requesting continuously (M reads) -> M granted 4 times, F granted on 5th arbitration, starve_cnt returns 0.
- M write addr 1024 -> m_gnt = 1, m_err = 1, mem_en = 0, array unchanged; F read addr 0xFFFF_0000 -> f_err = 1, no f_rvalid.
- Back-to-back M writes to addr 0..7 -> m_gnt every cycle, mem_en = mem_we = 1 eight consecutive cycles.
- MEM_LAT = 3: F read cycle N -> busy N+1..N+3, f_rvalid only in N+3, next grant N+4.
